// File: rtl/score_update_ctrl_if.sv
// Signal bundle between the push-button front end and the scoreboard controller.
// upd_valid is a one-cycle notification with no ready: the consumer must sample it in that cycle.
interface score_update_ctrl_if;
  logic [3:0]  btn;
  logic        clr;
  logic [15:0] num;
  logic        upd_valid;
  logic [1:0]  upd_idx;
  logic [3:0]  pending;

  modport master (
    output btn, clr,
    input  num, upd_valid, upd_idx, pending
  );

  modport slave (
    input  btn, clr,
    output num, upd_valid, upd_idx, pending
  );
endinterface

// File: rtl/score_update_ctrl.sv
// Debounces four raw buttons and increments the matching hex digit of a 16-bit
// scoreboard value through one shared incrementer, serving requests round-robin.
module score_update_ctrl #(
  parameter int          DB_CYCLES = 20,
  parameter int          DB_W      = 5,
  parameter logic [15:0] INIT_NUM  = 16'hABCD
) (
  input  logic                clk,
  input  logic                rst,
  score_update_ctrl_if.slave  bus,
  output logic                dbg_state
);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t            state;
  logic [3:0]        sync1, sync2;
  logic [3:0]        db, db_q;
  logic [DB_W-1:0]   cnt [4];
  logic [3:0]        pending;
  logic [1:0]        rr_ptr;
  logic [15:0]       num;
  logic              upd_valid;
  logic [1:0]        upd_idx;

  logic [3:0]        press;
  logic              gvalid;
  logic [1:0]        gidx;
  logic [1:0]        idx;
  logic [3:0]        grant;
  logic [3:0]        cur_digit, inc_digit;

  assign press = db & ~db_q;

  // Grants only once SERVE is registered, so a fresh request waits one cycle in IDLE.
  always_comb begin
    gvalid = 1'b0;
    gidx   = 2'd0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!gvalid && pending[idx]) begin
        gvalid = 1'b1;
        gidx   = idx;
      end
    end
    if (state != SERVE) gvalid = 1'b0;
    grant = gvalid ? (4'b0001 << gidx) : 4'b0000;
  end

  assign cur_digit = num[{gidx, 2'b00} +: 4];
  assign inc_digit = cur_digit + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sync1     <= '0;
      sync2     <= '0;
      db        <= '0;
      db_q      <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      pending   <= '0;
      rr_ptr    <= '0;
      num       <= INIT_NUM;
      upd_valid <= 1'b0;
      upd_idx   <= '0;
    end else begin
      sync1 <= bus.btn;
      sync2 <= sync1;
      db_q  <= db;

      // A level flips only after DB_CYCLES consecutive disagreeing samples.
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end

      if (bus.clr) begin
        num       <= INIT_NUM;
        pending   <= press;
        upd_valid <= 1'b0;
        state     <= IDLE;
      end else begin
        pending   <= (pending & ~grant) | press;
        upd_valid <= gvalid;
        if (gvalid) begin
          num[{gidx, 2'b00} +: 4] <= inc_digit;
          upd_idx                 <= gidx;
          rr_ptr                  <= gidx + 2'd1;
        end
        case (state)
          IDLE:    if (|pending) state <= SERVE;
          SERVE:   if (pending == 4'b0000) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.num       = num;
  assign bus.upd_valid = upd_valid;
  assign bus.upd_idx   = upd_idx;
  assign bus.pending   = pending;
  assign dbg_state     = state;

endmodule

// File: tb/tb_score_update_ctrl.sv
// Bench for score_update_ctrl: a small digit/round-robin model fills an expected
// queue of {idx, num} updates that a monitor pops on every upd_valid pulse.
module tb_score_update_ctrl;
  localparam int          DB   = 4;
  localparam logic [15:0] INIT = 16'hABCD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;

  score_update_ctrl_if bus();

  score_update_ctrl #(.DB_CYCLES(DB), .DB_W(3), .INIT_NUM(INIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int n_upd = 0;
  int last_upd_cyc = 0;

  logic [17:0] exp_q[$];
  logic [15:0] m_num;
  logic [1:0]  m_rr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: every update pulse must match the oldest expected entry.
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst && bus.upd_valid === 1'b1) begin
      n_upd++;
      last_upd_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_upd", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("upd_idx", 32'(bus.upd_idx), 32'(e[17:16]));
        check("upd_num", 32'(bus.num), 32'(e[15:0]));
      end
    end
  end

  // Model: buttons in mask are served in order starting at the current rr pointer.
  task automatic expect_presses(input logic [3:0] mask);
    logic [1:0] start, ix;
    start = m_rr;
    for (int k = 0; k < 4; k++) begin
      ix = start + 2'(k);
      if (mask[ix]) begin
        m_num[{ix, 2'b00} +: 4] = m_num[{ix, 2'b00} +: 4] + 4'd1;
        exp_q.push_back({ix, m_num});
        m_rr = ix + 2'd1;
      end
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic settle();
    repeat (2 * DB + 6) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask);
    expect_presses(mask);
    @(negedge clk);
    bus.btn = mask;
    repeat (12) @(negedge clk);
    bus.btn = 4'b0000;
    wait_drain();
    settle();
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    m_num = INIT;
    check("clr_num", 32'(bus.num), 32'(INIT));
  endtask

  initial begin
    int c0;
    int upd0;
    logic found;
    bus.btn = 4'b0000;
    bus.clr = 1'b0;
    m_num   = INIT;
    m_rr    = 2'd0;

    // 1: reset values, then quiet idle
    #12;
    check("rst_num", 32'(bus.num), 32'(INIT));
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
    check("rst_upd_idx", 32'(bus.upd_idx), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_num", 32'(bus.num), 32'(INIT));
    check("idle_pending", 32'(bus.pending), 32'd0);

    // 2: btn[0] held 20 cycles -> one update, DB+4 edges after first sample
    upd0 = n_upd;
    expect_presses(4'b0001);
    bus.btn = 4'b0001;
    c0 = cyc + 1;
    repeat (20) @(negedge clk);
    bus.btn = 4'b0000;
    wait_drain();
    settle();
    check("t2_latency", 32'(last_upd_cyc - c0), 32'(DB + 4));
    check("t2_count", 32'(n_upd - upd0), 32'd1);
    check("t2_num", 32'(bus.num), 32'h0000ABCE);

    // 3: bouncing btn[3] yields a single increment
    upd0 = n_upd;
    expect_presses(4'b1000);
    @(negedge clk);
    bus.btn[3] = 1'b1; @(negedge clk);
    bus.btn[3] = 1'b0; @(negedge clk);
    bus.btn[3] = 1'b1; @(negedge clk);
    bus.btn[3] = 1'b0; @(negedge clk);
    bus.btn[3] = 1'b1;
    repeat (12) @(negedge clk);
    bus.btn = 4'b0000;
    wait_drain();
    settle();
    check("t3_count", 32'(n_upd - upd0), 32'd1);
    check("t3_digit3", 32'(bus.num[15:12]), 32'hB);

    // 4: digit 0 wraps F->0 without carrying into digit 1
    do_clr();
    press(4'b0001);
    press(4'b0001);
    check("t4_pre", 32'(bus.num), 32'h0000ABCF);
    press(4'b0001);
    check("t4_wrap", 32'(bus.num), 32'h0000ABC0);
    check("t4_digit1", 32'(bus.num[7:4]), 32'hC);

    // 5: leave rr at 2, then all four at once -> 2,3,0,1
    press(4'b0010);
    do_clr();
    press(4'b1111);
    check("t5_num", 32'(bus.num), 32'h0000BCDE);

    // 6a: clr in the grant cycle of btn[1] suppresses the write
    do_clr();
    @(negedge clk);
    bus.btn = 4'b0010;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.pending[1] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_pend_seen", 32'(found), 32'd1);
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("t6_clr_num", 32'(bus.num), 32'(INIT));
    check("t6_clr_pending", 32'(bus.pending), 32'd0);
    check("t6_clr_no_upd", 32'(bus.upd_valid), 32'd0);
    repeat (4) @(negedge clk);
    bus.btn = 4'b0000;
    settle();
    check("t6_after_clr", 32'(bus.num), 32'(INIT));

    // 6b: rst while requests are pending clears everything at once
    bus.btn = 4'b1111;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.pending !== 4'b0000) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_rst_pend_seen", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_pending", 32'(bus.pending), 32'd0);
    check("t6_rst_num", 32'(bus.num), 32'(INIT));
    check("t6_rst_upd_valid", 32'(bus.upd_valid), 32'd0);
    bus.btn = 4'b0000;
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    m_num = INIT;
    m_rr  = 2'd0;
    repeat (20) @(negedge clk);
    check("t6_post_rst_num", 32'(bus.num), 32'(INIT));

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
